// File: rtl/beat_flash.sv
// -----------------------------------------------------------------------------
// beat_flash
//
// This block is the output side of the tap-tempo path. It takes a tempo in BPM
// and drives the beat strobe and the beat LED.
//   - It converts the tempo to a beat period, counted in tp_i ticks. A serial
//     restoring divider produces one quotient bit per clock.
//   - It issues a 1-clk beat strobe at each beat.
//   - It holds the LED on for FLASH_TICKS ticks after each beat.
//
// Optional feature macro: BEAT_RESYNC_EN
//   - Defined: a tempo change while running restarts the beat phase and emits
//     a beat as soon as the new period is loaded.
//   - Undefined: the beat phase is preserved and no extra beat is emitted.
//
// Ports
//   clk_i        in   1          clock
//   rst_i        in   1          reset, asynchronous, active-high
//   tp_i         in   1          time pulse, 1 clk wide, every PULSE_PER_NS
//   bpm_i        in   BPM_WIDTH  requested tempo; 0 = stop
//   bpm_valid_i  in   1          bpm_i valid
//   bpm_ready_o  out  1          block can accept bpm_i (low while dividing)
//   beat_o       out  1          1-clk strobe at each beat
//   led_o        out  1          stretched beat indicator
//   period_o     out  24         current beat period in ticks (0 when stopped)
// -----------------------------------------------------------------------------
module beat_flash #(
    parameter longint unsigned PULSE_PER_NS = 5120,
    parameter longint unsigned MINUTE_TICKS = 64'd60_000_000_000 / PULSE_PER_NS,
    parameter int unsigned     BPM_WIDTH    = 9,
    parameter int unsigned     BPM_MIN      = 30,
    parameter int unsigned     BPM_MAX      = 250,
    parameter int unsigned     FLASH_TICKS  = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tp_i,
    input  logic [BPM_WIDTH-1:0] bpm_i,
    input  logic                 bpm_valid_i,
    output logic                 bpm_ready_o,
    output logic                 beat_o,
    output logic                 led_o,
    output logic [23:0]          period_o
);

    localparam int unsigned FW = $clog2(FLASH_TICKS + 1);

    localparam logic [23:0]          MINUTE_V = 24'(MINUTE_TICKS);
    localparam logic [BPM_WIDTH-1:0] BPM_MIN_V = BPM_WIDTH'(BPM_MIN);
    localparam logic [BPM_WIDTH-1:0] BPM_MAX_V = BPM_WIDTH'(BPM_MAX);
    localparam logic [FW-1:0]        FLASH_V   = FW'(FLASH_TICKS);
    localparam logic [FW-1:0]        FLASH_ONE = FW'(1);
    localparam logic [4:0]           DIV_LAST  = 5'd24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           div_cnt_q, div_cnt_d;
    // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
    logic [23:0]          quo_q, quo_d;
    logic [BPM_WIDTH-1:0] rem_q, rem_d;
    logic [BPM_WIDTH-1:0] divisor_q, divisor_d;
    logic [23:0]          period_q, period_d;
    logic [23:0]          tick_q, tick_d;
    logic [FW-1:0]        flash_q, flash_d;
    logic                 beat_q, beat_d;
    logic                 led_q, led_d;
    // Set when the end of the division must restart the beat phase.
    logic                 entry_beat_q, entry_beat_d;

    logic                 accept;
    logic [BPM_WIDTH-1:0] bpm_clamped;
    logic [BPM_WIDTH:0]   rem_trial;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        divisor_d    = divisor_q;
        period_d     = period_q;
        tick_d       = tick_q;
        flash_d      = flash_q;
        entry_beat_d = entry_beat_q;
        beat_d       = 1'b0;

        accept = bpm_valid_i && (state_q != S_DIV);

        if (bpm_i < BPM_MIN_V) begin
            bpm_clamped = BPM_MIN_V;
        end else if (bpm_i > BPM_MAX_V) begin
            bpm_clamped = BPM_MAX_V;
        end else begin
            bpm_clamped = bpm_i;
        end

        rem_trial = {rem_q, quo_q[23]};

        if (tp_i && (flash_q != '0)) begin
            flash_d = flash_q - FLASH_ONE;
        end

        // The beat counter keeps running through a re-division. The >= compare
        // lets a shortened period fire on the next tick instead of wrapping.
        if (state_q == S_RUN && tp_i && (tick_q >= period_q - 24'd1)) begin
            tick_d  = '0;
            beat_d  = 1'b1;
            flash_d = FLASH_V;
        end else if (state_q != S_IDLE && tp_i) begin
            tick_d = tick_q + 24'd1;
        end

        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    if (bpm_i == '0) begin
                        state_d  = S_IDLE;
                        period_d = '0;
                        tick_d   = '0;
                        flash_d  = '0;
                        beat_d   = 1'b0;
                    end else begin
                        state_d   = S_DIV;
                        divisor_d = bpm_clamped;
                        quo_d     = MINUTE_V;
                        rem_d     = '0;
                        div_cnt_d = '0;
`ifdef BEAT_RESYNC_EN
                        entry_beat_d = 1'b1;
`else
                        entry_beat_d = (state_q == S_IDLE);
`endif
                    end
                end
            end
            S_DIV: begin
                if (div_cnt_q == DIV_LAST) begin
                    period_d = quo_q;
                    state_d  = S_RUN;
                    if (entry_beat_q) begin
                        tick_d  = '0;
                        beat_d  = 1'b1;
                        flash_d = FLASH_V;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 5'd1;
                    if (rem_trial >= {1'b0, divisor_q}) begin
                        rem_d = BPM_WIDTH'(rem_trial - {1'b0, divisor_q});
                        quo_d = {quo_q[22:0], 1'b1};
                    end else begin
                        rem_d = rem_trial[BPM_WIDTH-1:0];
                        quo_d = {quo_q[22:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        led_d = (flash_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            divisor_q    <= '0;
            period_q     <= '0;
            tick_q       <= '0;
            flash_q      <= '0;
            beat_q       <= 1'b0;
            led_q        <= 1'b0;
            entry_beat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            divisor_q    <= divisor_d;
            period_q     <= period_d;
            tick_q       <= tick_d;
            flash_q      <= flash_d;
            beat_q       <= beat_d;
            led_q        <= led_d;
            entry_beat_q <= entry_beat_d;
        end
    end

    assign bpm_ready_o = (state_q != S_DIV);
    assign beat_o      = beat_q;
    assign led_o       = led_q;
    assign period_o    = period_q;

endmodule

// File: tb/tb_beat_flash.sv
// -----------------------------------------------------------------------------
// tb_beat_flash
//
// Directed testbench for beat_flash, using MINUTE_TICKS=6000 and FLASH_TICKS=10.
// A second instance with FLASH_TICKS=60 covers the case where the LED stays on
// continuously. Expected values are hand-computed from the tempo arithmetic:
// 6000/120=50, 6000/30=200, 6000/250=24, 6000/60=100.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_beat_flash;

`ifdef BEAT_RESYNC_EN
    localparam logic RESYNC = 1'b1;
`else
    localparam logic RESYNC = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tp_i;
    logic [8:0]  bpm_i;
    logic        bpm_valid_i;
    logic        bpm_ready_o, beat_o, led_o;
    logic [23:0] period_o;
    logic        ready_long, beat_long, led_long;
    logic [23:0] period_long;

    int n_checks = 0;
    int n_fail   = 0;

    beat_flash #(.MINUTE_TICKS(6000), .FLASH_TICKS(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .bpm_i(bpm_i),
        .bpm_valid_i(bpm_valid_i), .bpm_ready_o(bpm_ready_o),
        .beat_o(beat_o), .led_o(led_o), .period_o(period_o)
    );

    beat_flash #(.MINUTE_TICKS(6000), .FLASH_TICKS(60)) dut_long (
        .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .bpm_i(bpm_i),
        .bpm_valid_i(bpm_valid_i), .bpm_ready_o(ready_long),
        .beat_o(beat_long), .led_o(led_long), .period_o(period_long)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One tp_i pulse followed by one idle clock. The outputs are captured just
    // after the clock edge that consumes the pulse.
    task automatic tp_pulse(output logic b, output logic l, output logic ll);
        tp_i = 1'b1;
        tick();
        b  = beat_o;
        l  = led_o;
        ll = led_long;
        tp_i = 1'b0;
        tick();
    endtask

    task automatic accept(input logic [8:0] v);
        bpm_i       = v;
        bpm_valid_i = 1'b1;
        tick();
        bpm_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; tp_i = 1'b0; bpm_i = '0; bpm_valid_i = 1'b0;
        repeat (3) tick();
        n_checks++; if (beat_o !== 1'b0) begin n_fail++; $display("FAIL reset_beat: got %b expected 0", beat_o); end
        n_checks++; if (led_o !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b expected 0", led_o); end
        n_checks++; if (period_o !== 24'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period_o); end
        n_checks++; if (bpm_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bpm_ready_o); end
        rst_i = 1'b0;
        tick();
        $display("reset: beat=%b led=%b period=%0d ready=%b", beat_o, led_o, period_o, bpm_ready_o);
    endtask

    task automatic test_first_tempo();
        logic b, l, ll;
        accept(9'd120);
        n_checks++; if (bpm_ready_o !== 1'b0) begin n_fail++; $display("FAIL div_ready_c0: got %b expected 0", bpm_ready_o); end
        for (int i = 1; i <= 24; i++) begin
            tick();
            n_checks++; if (bpm_ready_o !== 1'b0) begin n_fail++; $display("FAIL div_ready_c%0d: got %b expected 0", i, bpm_ready_o); end
        end
        tick();
        n_checks++; if (bpm_ready_o !== 1'b1) begin n_fail++; $display("FAIL div_ready_c25: got %b expected 1", bpm_ready_o); end
        n_checks++; if (period_o !== 24'd50) begin n_fail++; $display("FAIL period_120: got %0d expected 50", period_o); end
        n_checks++; if (beat_o !== 1'b1) begin n_fail++; $display("FAIL first_beat: got %b expected 1", beat_o); end
        n_checks++; if (led_o !== 1'b1) begin n_fail++; $display("FAIL first_led: got %b expected 1", led_o); end
        tick();
        n_checks++; if (beat_o !== 1'b0) begin n_fail++; $display("FAIL beat_width: got %b expected 0", beat_o); end
        for (int i = 1; i <= 50; i++) begin
            tp_pulse(b, l, ll);
            n_checks++; if (b !== (i == 50)) begin n_fail++; $display("FAIL beat_tp%0d: got %b expected %b", i, b, (i == 50)); end
            if (i == 9) begin
                n_checks++; if (l !== 1'b1) begin n_fail++; $display("FAIL led_tp9: got %b expected 1", l); end
            end
            if (i == 10) begin
                n_checks++; if (l !== 1'b0) begin n_fail++; $display("FAIL led_tp10: got %b expected 0", l); end
            end
            if (i == 50) begin
                n_checks++; if (l !== 1'b1) begin n_fail++; $display("FAIL led_tp50: got %b expected 1", l); end
            end
        end
        $display("first_tempo: bpm=120 period=%0d beat every 50 tp", period_o);
    endtask

    task automatic test_clamp();
        logic b, l, ll;
        accept(9'd10);
        repeat (25) tick();
        n_checks++; if (period_o !== 24'd200) begin n_fail++; $display("FAIL clamp_low: got %0d expected 200", period_o); end
        n_checks++; if (beat_o !== RESYNC) begin n_fail++; $display("FAIL clamp_exit_beat: got %b expected %b", beat_o, RESYNC); end
        $display("clamp: bpm=10 period=%0d", period_o);
        accept(9'd400);
        repeat (25) tick();
        n_checks++; if (period_o !== 24'd24) begin n_fail++; $display("FAIL clamp_high: got %0d expected 24", period_o); end
        $display("clamp: bpm=400 period=%0d", period_o);
        accept(9'd0);
        n_checks++; if (period_o !== 24'd0) begin n_fail++; $display("FAIL stop_period: got %0d expected 0", period_o); end
        n_checks++; if (led_o !== 1'b0) begin n_fail++; $display("FAIL stop_led: got %b expected 0", led_o); end
        n_checks++; if (bpm_ready_o !== 1'b1) begin n_fail++; $display("FAIL stop_ready: got %b expected 1", bpm_ready_o); end
        for (int i = 1; i <= 5; i++) begin
            tp_pulse(b, l, ll);
            n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL stop_beat_tp%0d: got %b expected 0", i, b); end
        end
        $display("clamp: bpm=0 period=%0d led=%b", period_o, led_o);
    endtask

    task automatic test_busy_ignore();
        accept(9'd120);
        repeat (25) tick();
        n_checks++; if (beat_o !== 1'b1) begin n_fail++; $display("FAIL idle_entry_beat: got %b expected 1", beat_o); end
        accept(9'd120);
        bpm_i = 9'd60; bpm_valid_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (bpm_ready_o !== 1'b0) begin n_fail++; $display("FAIL busy_ready_c%0d: got %b expected 0", i, bpm_ready_o); end
        end
        bpm_valid_i = 1'b0;
        repeat (15) tick();
        n_checks++; if (period_o !== 24'd50) begin n_fail++; $display("FAIL busy_ignored: got %0d expected 50", period_o); end
        n_checks++; if (bpm_ready_o !== 1'b1) begin n_fail++; $display("FAIL busy_ready_end: got %b expected 1", bpm_ready_o); end
        accept(9'd60);
        repeat (25) tick();
        n_checks++; if (period_o !== 24'd100) begin n_fail++; $display("FAIL period_60: got %0d expected 100", period_o); end
        $display("busy_ignore: period=%0d after accepting 60", period_o);
    endtask

    task automatic test_tempo_change();
        logic b, l, ll;
        accept(9'd0);
        accept(9'd60);
        repeat (25) tick();
        for (int i = 1; i <= 70; i++) begin
            tp_pulse(b, l, ll);
            n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL pre_change_tp%0d: got %b expected 0", i, b); end
        end
        accept(9'd120);
        repeat (25) tick();
        n_checks++; if (beat_o !== RESYNC) begin n_fail++; $display("FAIL change_exit_beat: got %b expected %b", beat_o, RESYNC); end
        n_checks++; if (period_o !== 24'd50) begin n_fail++; $display("FAIL change_period: got %0d expected 50", period_o); end
`ifndef BEAT_RESYNC_EN
        tp_pulse(b, l, ll);
        n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL change_late_beat: got %b expected 1", b); end
`endif
        for (int i = 1; i <= 50; i++) begin
            tp_pulse(b, l, ll);
            n_checks++; if (b !== (i == 50)) begin n_fail++; $display("FAIL change_tp%0d: got %b expected %b", i, b, (i == 50)); end
        end
        $display("tempo_change: 60->120 at tick 70, resync=%b", RESYNC);
    endtask

    task automatic test_flash_hold();
        logic b, l, ll;
        accept(9'd0);
        n_checks++; if (led_long !== 1'b0) begin n_fail++; $display("FAIL hold_idle_led: got %b expected 0", led_long); end
        accept(9'd120);
        repeat (25) tick();
        n_checks++; if (led_long !== 1'b1) begin n_fail++; $display("FAIL hold_first_led: got %b expected 1", led_long); end
        for (int i = 1; i <= 120; i++) begin
            tp_pulse(b, l, ll);
            n_checks++; if (ll !== 1'b1) begin n_fail++; $display("FAIL hold_led_tp%0d: got %b expected 1", i, ll); end
            if (i == 10) begin
                n_checks++; if (l !== 1'b0) begin n_fail++; $display("FAIL short_led_tp10: got %b expected 0", l); end
            end
        end
        $display("flash_hold: FLASH_TICKS=60 led held over 120 tp");
    endtask

    task automatic test_reset_mid();
        logic b, l, ll;
        accept(9'd0);
        accept(9'd120);
        repeat (25) tick();
        repeat (3) tp_pulse(b, l, ll);
        accept(9'd60);
        repeat (5) tick();
        n_checks++; if (led_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_led: got %b expected 1", led_o); end
        rst_i = 1'b1;
        #1;
        n_checks++; if (led_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_led: got %b expected 0", led_o); end
        n_checks++; if (led_long !== 1'b0) begin n_fail++; $display("FAIL mid_rst_led_long: got %b expected 0", led_long); end
        n_checks++; if (period_o !== 24'd0) begin n_fail++; $display("FAIL mid_rst_period: got %0d expected 0", period_o); end
        n_checks++; if (bpm_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", bpm_ready_o); end
        n_checks++; if (beat_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_beat: got %b expected 0", beat_o); end
        repeat (2) tick();
        rst_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tp_pulse(b, l, ll);
            n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL post_rst_beat_tp%0d: got %b expected 0", i, b); end
        end
        n_checks++; if (bpm_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", bpm_ready_o); end
        $display("reset_mid: outputs cleared, ready=%b", bpm_ready_o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_tempo();
        test_clamp();
        test_busy_ignore();
        test_tempo_change();
        test_flash_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
